// File: rtl/icache_pkg.sv
// ----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the n-way instruction cache:
//   state_t         controller state enumeration
//   calc_off_bits() word-offset field width for a given line size
//   calc_tag_len()  tag field width for a given set count and line size
// ----------------------------------------------------------------------------
package icache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        REFILL,
        DONE
    } state_t;

    // Number of address bits that select a 32-bit word inside a line.
    function automatic int calc_off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    // Tag width: 32 address bits minus the byte offset (2), set index and word offset.
    function automatic int calc_tag_len(input int set_bits, input int line_words);
        return 30 - set_bits - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_lru.sv
// ----------------------------------------------------------------------------
// icache_lru
// Age-based LRU helper for a single cache set (purely combinational).
// Ports:
//   age_in     packed per-way ages of the set (way i at [i*AGE_BITS +: AGE_BITS])
//   use_way    way being accessed
//   age_out    ages after accessing use_way
//   oldest_way way holding the maximum age (replacement candidate)
// ----------------------------------------------------------------------------
module icache_lru #(
    parameter int WAYS     = 4,
    parameter int AGE_BITS = 2
) (
    input  logic [WAYS*AGE_BITS-1:0] age_in,
    input  logic [AGE_BITS-1:0]      use_way,
    output logic [WAYS*AGE_BITS-1:0] age_out,
    output logic [AGE_BITS-1:0]      oldest_way
);

    logic [AGE_BITS-1:0] used_age;
    logic [AGE_BITS-1:0] max_age;

    assign used_age = age_in[int'(use_way)*AGE_BITS +: AGE_BITS];

    // Ways younger than the accessed one age by one and the accessed way
    // becomes youngest, so the ages remain a permutation of 0..WAYS-1.
    always_comb begin
        age_out = age_in;
        for (int i = 0; i < WAYS; i++) begin
            if (i == int'(use_way)) begin
                age_out[i*AGE_BITS +: AGE_BITS] = '0;
            end else if (age_in[i*AGE_BITS +: AGE_BITS] < used_age) begin
                age_out[i*AGE_BITS +: AGE_BITS] = age_in[i*AGE_BITS +: AGE_BITS] + AGE_BITS'(1);
            end
        end
    end

    always_comb begin
        oldest_way = '0;
        max_age    = age_in[AGE_BITS-1:0];
        for (int i = 1; i < WAYS; i++) begin
            if (age_in[i*AGE_BITS +: AGE_BITS] > max_age) begin
                max_age    = age_in[i*AGE_BITS +: AGE_BITS];
                oldest_way = AGE_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/icache_nway.sv
// ----------------------------------------------------------------------------
// icache_nway
// Set-associative instruction cache with age-based LRU replacement and a
// burst refill interface toward memory.
// Ports:
//   clk, rst      clock (rising edge) and asynchronous active-high reset
//   req, insaddr  fetch request and word-aligned fetch address
//   inv           invalidate every line (honoured in IDLE only)
//   ins, ok       fetched instruction and its one-cycle completion pulse
//   miss          high while a refill is in progress for the current request
//   sen, addr     memory request strobe and line-aligned refill address
//   addr_ok       memory accepted the refill request
//   data_ok,burst refill beat valid / final beat marker
//   sdata         refill beat data
// ----------------------------------------------------------------------------
module icache_nway
    import icache_pkg::*;
#(
    parameter int WAYS       = 4,
    parameter int SET_BITS   = 6,
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] insaddr,
    input  logic        inv,
    output logic [31:0] ins,
    output logic        ok,
    output logic        miss,
    output logic        sen,
    output logic [31:0] addr,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic        burst,
    input  logic [31:0] sdata
);

    localparam int OFF_BITS = calc_off_bits(LINE_WORDS);
    localparam int TAG_LEN  = calc_tag_len(SET_BITS, LINE_WORDS);
    localparam int SETS     = 1 << SET_BITS;
    localparam int AGE_BITS = $clog2(WAYS);

    state_t state;

    // Latched request and its address fields
    logic [31:0]           lat_addr;
    logic [TAG_LEN-1:0]    lat_tag;
    logic [SET_BITS-1:0]   lat_set;
    logic [OFF_BITS-1:0]   lat_off;

    // Storage
    logic [TAG_LEN-1:0]    tag_mem  [WAYS][SETS];
    logic [31:0]           data_mem [WAYS][SETS*LINE_WORDS];
    logic [WAYS-1:0]       valid    [SETS];
    logic [WAYS*AGE_BITS-1:0] age   [SETS];

    // Synchronous read path
    logic [SET_BITS-1:0]   rd_set;
    logic [OFF_BITS-1:0]   rd_off;
    logic [TAG_LEN-1:0]    tag_rd   [WAYS];
    logic [31:0]           data_rd  [WAYS];

    // Lookup results
    logic [WAYS-1:0]       match;
    logic                  hit;
    logic                  lookup_hit;
    logic                  accept;
    logic [AGE_BITS-1:0]   hit_way;
    logic [31:0]           hit_word;

    // Replacement
    logic [AGE_BITS-1:0]   victim;
    logic [AGE_BITS-1:0]   victim_sel;
    logic                  invalid_found;
    logic [AGE_BITS-1:0]   lru_way;
    logic [AGE_BITS-1:0]   lru_oldest;
    logic [WAYS*AGE_BITS-1:0] age_next;
    logic                  age_upd;

    // Refill bookkeeping and registered outputs
    logic [OFF_BITS-1:0]   beat;
    logic [31:0]           cap_word;
    logic                  ok_q;
    logic [31:0]           ins_q;

    assign lat_tag = lat_addr[31 -: TAG_LEN];
    assign lat_set = lat_addr[OFF_BITS+2 +: SET_BITS];
    assign lat_off = lat_addr[2 +: OFF_BITS];

    assign lookup_hit = (state == LOOKUP) && hit;

    // A request is taken in IDLE (unless invalidating) or on a hit cycle,
    // which lets a held req stream one hit per cycle.
    assign accept = ((state == IDLE) && !inv && req) || (lookup_hit && req);

    // The arrays are addressed by the incoming address on the accepting edge
    // so that the registered read lines up with the following LOOKUP cycle.
    assign rd_set = accept ? insaddr[OFF_BITS+2 +: SET_BITS] : lat_set;
    assign rd_off = accept ? insaddr[2 +: OFF_BITS]          : lat_off;

    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            tag_rd[w]  <= tag_mem[w][rd_set];
            data_rd[w] <= data_mem[w][{rd_set, rd_off}];
        end
    end

    always_ff @(posedge clk) begin
        if (state == REFILL && data_ok) begin
            data_mem[victim][{lat_set, beat}] <= sdata;
        end
        if (state == DONE) begin
            tag_mem[victim][lat_set] <= lat_tag;
        end
    end

    // Only a match in exactly one way is treated as a hit.
    always_comb begin
        match   = '0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            match[w] = valid[lat_set][w] && (tag_rd[w] == lat_tag);
        end
        for (int w = 0; w < WAYS; w++) begin
            if (match[w]) begin
                hit_way = AGE_BITS'(w);
            end
        end
        hit = $onehot(match);
    end

    assign hit_word = data_rd[hit_way];

    // Fill the lowest-numbered empty way first; only a full set evicts by age.
    always_comb begin
        victim_sel    = lru_oldest;
        invalid_found = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!invalid_found && !valid[lat_set][w]) begin
                victim_sel    = AGE_BITS'(w);
                invalid_found = 1'b1;
            end
        end
    end

    assign lru_way = (state == DONE) ? victim : hit_way;
    assign age_upd = lookup_hit || (state == DONE);

    icache_lru #(
        .WAYS     (WAYS),
        .AGE_BITS (AGE_BITS)
    ) u_lru (
        .age_in     (age[lat_set]),
        .use_way    (lru_way),
        .age_out    (age_next),
        .oldest_way (lru_oldest)
    );

    // Valid bits and ages. A line only becomes valid in DONE, so a refill cut
    // short by reset never leaves a partially written line visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    age[s][w*AGE_BITS +: AGE_BITS] <= AGE_BITS'(w);
                end
            end
        end else begin
            if (state == IDLE && inv) begin
                for (int s = 0; s < SETS; s++) begin
                    valid[s] <= '0;
                end
            end
            if (state == DONE) begin
                valid[lat_set][victim] <= 1'b1;
            end
            if (age_upd) begin
                age[lat_set] <= age_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            lat_addr <= '0;
            beat     <= '0;
            victim   <= '0;
            cap_word <= '0;
            ok_q     <= 1'b0;
            ins_q    <= '0;
            miss     <= 1'b0;
            sen      <= 1'b0;
            addr     <= '0;
        end else begin
            ok_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!inv && req) begin
                        lat_addr <= insaddr;
                        state    <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (req) begin
                            lat_addr <= insaddr;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        victim <= victim_sel;
                        miss   <= 1'b1;
                        sen    <= 1'b1;
                        addr   <= {lat_addr[31:OFF_BITS+2], {(OFF_BITS+2){1'b0}}};
                        state  <= MISS_REQ;
                    end
                end
                MISS_REQ: begin
                    if (addr_ok) begin
                        sen   <= 1'b0;
                        beat  <= '0;
                        state <= REFILL;
                    end
                end
                REFILL: begin
                    if (data_ok) begin
                        beat <= beat + OFF_BITS'(1);
                        if (beat == lat_off) begin
                            cap_word <= sdata;
                        end
                        if (burst) begin
                            ok_q  <= 1'b1;
                            ins_q <= (beat == lat_off) ? sdata : cap_word;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    miss  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Hits complete in the LOOKUP cycle itself, straight off the registered
    // array read; refills complete from the DONE-state registers.
    assign ok  = ok_q | lookup_hit;
    assign ins = lookup_hit ? hit_word : ins_q;

endmodule

// File: tb/tb_icache_nway.sv
// ----------------------------------------------------------------------------
// tb_icache_nway
// Randomised scoreboard bench for icache_nway (WAYS=4, SET_BITS=6,
// LINE_WORDS=8). The reference keeps, per cached line, the time of its last
// use; a full set evicts its least recently used line.
// ----------------------------------------------------------------------------
module tb_icache_nway;

    localparam int WAYS       = 4;
    localparam int SET_BITS   = 6;
    localparam int LINE_WORDS = 8;
    localparam int SETS       = 1 << SET_BITS;
    localparam int LINE_SHIFT = $clog2(LINE_WORDS * 4);

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] insaddr;
    logic        inv;
    logic [31:0] ins;
    logic        ok;
    logic        miss;
    logic        sen;
    logic [31:0] addr;
    logic        addr_ok = 1'b0;
    logic        data_ok = 1'b0;
    logic        burst   = 1'b0;
    logic [31:0] sdata   = '0;

    always #5 clk = ~clk;

    icache_nway #(
        .WAYS       (WAYS),
        .SET_BITS   (SET_BITS),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .insaddr (insaddr),
        .inv     (inv),
        .ins     (ins),
        .ok      (ok),
        .miss    (miss),
        .sen     (sen),
        .addr    (addr),
        .addr_ok (addr_ok),
        .data_ok (data_ok),
        .burst   (burst),
        .sdata   (sdata)
    );

    typedef struct {
        logic [31:0] data;
        bit          hit;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    longint      last_use [int unsigned];
    longint      tick = 0;

    int          fixed_delay = -1;
    bit          stray = 1'b0;
    int          beats_sent = 0;

    logic [31:0] fill_list [4];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Backing memory contents: line 0x1000 holds 0xA0..0xA7, every other word
    // holds a value derived from its own address.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w[31:5] == 27'h80) begin
            return 32'hA0 + {29'd0, w[4:2]};
        end
        return w ^ 32'hC0DE_0000;
    endfunction

    // Reference cache: returns 1 on hit, and records the access.
    function automatic bit model_access(input logic [31:0] a);
        int unsigned line;
        int unsigned set_idx;
        int unsigned victim_line;
        int          cnt;
        longint      oldest;
        line    = a >> LINE_SHIFT;
        set_idx = line % SETS;
        tick++;
        if (last_use.exists(line)) begin
            last_use[line] = tick;
            return 1'b1;
        end
        cnt         = 0;
        oldest      = 0;
        victim_line = 0;
        foreach (last_use[k]) begin
            if (k % SETS == set_idx) begin
                cnt++;
                if (cnt == 1 || last_use[k] < oldest) begin
                    oldest      = last_use[k];
                    victim_line = k;
                end
            end
        end
        if (cnt >= WAYS) begin
            last_use.delete(victim_line);
        end
        last_use[line] = tick;
        return 1'b0;
    endfunction

    task automatic predict(input logic [31:0] a);
        bit   h;
        exp_t e;
        h      = model_access(a);
        e.data = mem_val(a);
        e.hit  = h;
        exp_q.push_back(e);
        if (!h) begin
            exp_addr_q.push_back({a[31:LINE_SHIFT], {LINE_SHIFT{1'b0}}});
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a);
        bit got;
        @(negedge clk);
        predict(a);
        req     = 1'b1;
        insaddr = a;
        @(negedge clk);
        req     = 1'b0;
        insaddr = $urandom;
        got     = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (ok) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL ok timeout for 0x%08h: got no ok, expected ok within 300 cycles", a);
        end
    endtask

    // Three back-to-back fetches with req held high; all must hit.
    task automatic applyStream(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        @(negedge clk);
        predict(a0);
        predict(a1);
        predict(a2);
        req     = 1'b1;
        insaddr = a0;
        @(negedge clk);
        checkOutput("stream ok 0", 32'(ok), 32'd1);
        insaddr = a1;
        @(negedge clk);
        checkOutput("stream ok 1", 32'(ok), 32'd1);
        insaddr = a2;
        @(negedge clk);
        checkOutput("stream ok 2", 32'(ok), 32'd1);
        req = 1'b0;
        @(negedge clk);
        checkOutput("stream ok idle", 32'(ok), 32'd0);
    endtask

    // req is raised alongside inv to show it is ignored in that cycle.
    task automatic applyInvalidate();
        @(negedge clk);
        inv     = 1'b1;
        req     = 1'b1;
        insaddr = $urandom;
        @(negedge clk);
        inv = 1'b0;
        req = 1'b0;
        last_use.delete();
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " ins"},  ins,          32'd0);
        checkOutput({tag, " ok"},   32'(ok),      32'd0);
        checkOutput({tag, " miss"}, 32'(miss),    32'd0);
        checkOutput({tag, " sen"},  32'(sen),     32'd0);
        checkOutput({tag, " addr"}, addr,         32'd0);
    endtask

    // Memory responder: accepts a refill request after a delay, then sends
    // LINE_WORDS beats with random gaps. With stray set it also pulses junk
    // beats while no refill is in progress.
    initial begin
        int          phase;
        int          cnt;
        int          gap;
        int          beat;
        logic [31:0] line;
        phase = 0;
        cnt   = 0;
        gap   = 0;
        beat  = 0;
        line  = '0;
        forever begin
            @(negedge clk);
            addr_ok = 1'b0;
            data_ok = 1'b0;
            burst   = 1'b0;
            if (rst) begin
                phase      = 0;
                beats_sent = 0;
            end else begin
                case (phase)
                    0: begin
                        if (sen) begin
                            line       = addr;
                            cnt        = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                            beats_sent = 0;
                            phase      = 1;
                        end else if (stray) begin
                            data_ok = 1'($urandom_range(0, 1));
                            burst   = 1'b1;
                            sdata   = $urandom;
                        end
                    end
                    1: begin
                        if (cnt == 0) begin
                            addr_ok = 1'b1;
                            gap     = $urandom_range(0, 3);
                            beat    = 0;
                            phase   = 2;
                        end else begin
                            cnt--;
                            if (stray) begin
                                data_ok = 1'b1;
                                burst   = 1'b1;
                                sdata   = $urandom;
                            end
                        end
                    end
                    default: begin
                        if (gap == 0) begin
                            data_ok = 1'b1;
                            sdata   = mem_val(line + 32'(beat * 4));
                            burst   = (beat == LINE_WORDS - 1);
                            beat++;
                            beats_sent++;
                            gap = $urandom_range(0, 3);
                            if (beat == LINE_WORDS) begin
                                phase = 0;
                            end
                        end else begin
                            gap--;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: checks refill addresses while sen is high and pops one
    // expectation per ok pulse.
    initial begin
        bit   saw_miss;
        exp_t e;
        saw_miss = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                saw_miss = 1'b0;
            end else begin
                if (miss) begin
                    saw_miss = 1'b1;
                end
                if (sen) begin
                    if (exp_addr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("[TB] FAIL unexpected sen: got sen=1 addr 0x%08h, expected no refill", addr);
                    end else begin
                        checkOutput("refill addr", addr, exp_addr_q[0]);
                    end
                end
                if (ok) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("[TB] FAIL unexpected ok: got ok=1 ins 0x%08h, expected no completion", ins);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("ins", ins, e.data);
                        checkOutput("hit", {31'd0, !saw_miss}, {31'd0, e.hit});
                        if (!e.hit && exp_addr_q.size() > 0) begin
                            void'(exp_addr_q.pop_front());
                        end
                    end
                    saw_miss = 1'b0;
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        bit          fired;

        rst     = 1'b1;
        req     = 1'b0;
        inv     = 1'b0;
        insaddr = '0;
        fill_list = '{32'h0000_0000, 32'h0000_0800, 32'h0000_1000, 32'h0000_1800};

        @(negedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        // Cold miss then a hit in the same line
        applyStimulus(32'h0000_1004);
        applyStimulus(32'h0000_1008);

        // Junk beats while idle must not disturb anything
        stray = 1'b1;
        repeat (4) @(negedge clk);
        stray = 1'b0;

        applyStream(32'h0000_1000, 32'h0000_1004, 32'h0000_1008);

        // Invalidate forces a refetch
        applyInvalidate();
        applyStimulus(32'h0000_1004);

        // LRU replacement within set 0
        applyInvalidate();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(fill_list[i]);
        end
        applyStimulus(32'h0000_0000);
        applyStimulus(32'h0000_2000);
        applyStimulus(32'h0000_0800);
        applyStimulus(32'h0000_0000);

        // Slow memory acceptance with junk beats before addr_ok, then read
        // back every word of the line
        fixed_delay = 5;
        stray       = 1'b1;
        applyStimulus(32'h0000_4010);
        stray       = 1'b0;
        fixed_delay = -1;
        for (int i = 0; i < LINE_WORDS; i++) begin
            applyStimulus(32'h0000_4000 + 32'(i * 4));
        end

        // Random traffic over a small pool of lines to force evictions
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 24) == 0) begin
                applyInvalidate();
            end else begin
                a = (32'($urandom_range(0, 5)) << 11) |
                    (32'($urandom_range(0, 2)) << 5)  |
                    (32'($urandom_range(0, 7)) << 2);
                applyStimulus(a);
            end
        end

        // Reset during the third refill beat
        applyInvalidate();
        a = 32'h0000_3008;
        @(negedge clk);
        predict(a);
        req     = 1'b1;
        insaddr = a;
        @(negedge clk);
        req   = 1'b0;
        fired = 1'b0;
        for (int i = 0; i < 300; i++) begin
            #1;
            if (data_ok && beats_sent == 3) begin
                rst   = 1'b1;
                fired = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!fired) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL third beat: got no third refill beat, expected one within 300 cycles");
        end
        @(negedge clk);
        checkResetOutputs("mid-refill reset");
        exp_q.delete();
        exp_addr_q.delete();
        last_use.delete();
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(a);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
